mpc_constraint_vec_writer: RTL and testbench

//   Write-side counterpart of the constraint bound-vector ROMs used by mpc_dense_constraint.

---
 rtl/mpc_constraint_vec_writer_if.sv | 12 +
 rtl/mpc_constraint_vec_writer.sv | 153 +++++++++++++++
 tb/tb_mpc_constraint_vec_writer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mpc_constraint_vec_writer_if.sv
// Framed write stream carrying constraint bound words from the host into the bank writer.
interface mpc_constraint_vec_writer_if #(
  parameter int DataWidth = 18
);
  logic [DataWidth-1:0] s_data;
  logic                 s_valid;
  logic                 s_last;
  logic                 s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/mpc_constraint_vec_writer.sv
// Double-buffered constraint bound-vector store: framed writes fill the shadow bank,
// the solver reads the active bank through a ROM-style registered port and swaps on request.
module mpc_constraint_vec_writer #(
  parameter int DataWidth    = 18,
  parameter int AddressWidth = 3,
  parameter int AddressRange = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  mpc_constraint_vec_writer_if.slave wr,
  input  logic [AddressWidth-1:0] address0,
  input  logic                    ce0,
  output logic [DataWidth-1:0]    q0,
  input  logic                    swap_req,
  output logic                    bank_sel,
  output logic                    load_done,
  output logic                    err_len
);

  typedef enum logic [1:0] {IDLE, LOAD, PENDING} state_t;
  typedef logic [DataWidth-1:0] bank_t [AddressRange];

  localparam logic [AddressWidth-1:0] LastSlot = AddressWidth'(AddressRange - 1);

  // Power-on image matches the bound ROM it replaces: alternating even/odd defaults.
  function automatic bank_t init_bank();
    bank_t b;
    for (int i = 0; i < AddressRange; i++) begin
      b[i] = i[0] ? DataWidth'(18'h26DE0) : DataWidth'(18'h38000);
    end
    return b;
  endfunction

  bank_t bank0_q = init_bank();
  bank_t bank1_q = init_bank();

  state_t                  state_q, state_d;
  logic [AddressWidth-1:0] wr_cnt_q, wr_cnt_d;
  logic                    s_ready_q, s_ready_d;
  logic                    bank_sel_q, bank_sel_d;
  logic                    load_done_q, load_done_d;
  logic                    err_len_q, err_len_d;
  logic [DataWidth-1:0]    q0_q, q0_d;
  logic                    wr_en;
  logic                    beat;
  logic [DataWidth-1:0]    rd_word;

  assign beat = wr.s_valid & s_ready_q;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    bank_sel_d  = bank_sel_q;
    load_done_d = 1'b0;
    err_len_d   = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          wr_en = 1'b1;
          if (wr.s_last) begin
            err_len_d = 1'b1;
            wr_cnt_d  = '0;
          end else begin
            state_d  = LOAD;
            wr_cnt_d = AddressWidth'(1);
          end
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (wr_cnt_q == LastSlot) begin
            // Last slot filled: only a matching s_last makes the frame committable.
            wr_cnt_d = '0;
            if (wr.s_last) begin
              state_d = PENDING;
            end else begin
              state_d   = IDLE;
              err_len_d = 1'b1;
            end
          end else if (wr.s_last) begin
            state_d   = IDLE;
            err_len_d = 1'b1;
            wr_cnt_d  = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + AddressWidth'(1);
          end
        end
      end
      PENDING: begin
        if (swap_req) begin
          bank_sel_d  = ~bank_sel_q;
          load_done_d = 1'b1;
          state_d     = IDLE;
          wr_cnt_d    = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        wr_cnt_d = '0;
      end
    endcase
    s_ready_d = (state_d != PENDING);
  end

  // Read uses the pre-edge bank select, so a read on the swap edge still sees the old bank.
  always_comb begin
    rd_word = bank_sel_q ? bank1_q[address0] : bank0_q[address0];
    q0_d    = q0_q;
    if (ce0) begin
      q0_d = (32'(address0) >= AddressRange) ? '0 : rd_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      s_ready_q   <= 1'b0;
      bank_sel_q  <= 1'b0;
      load_done_q <= 1'b0;
      err_len_q   <= 1'b0;
      q0_q        <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      s_ready_q   <= s_ready_d;
      bank_sel_q  <= bank_sel_d;
      load_done_q <= load_done_d;
      err_len_q   <= err_len_d;
      q0_q        <= q0_d;
    end
  end

  // Storage is not reset; writes only ever land in the shadow bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (bank_sel_q) begin
        bank0_q[wr_cnt_q] <= wr.s_data;
      end else begin
        bank1_q[wr_cnt_q] <= wr.s_data;
      end
    end
  end

  assign wr.s_ready = s_ready_q;
  assign q0         = q0_q;
  assign bank_sel   = bank_sel_q;
  assign load_done  = load_done_q;
  assign err_len    = err_len_q;

endmodule

// File: tb/tb_mpc_constraint_vec_writer.sv
// Randomized bench for the double-buffered constraint vector writer, checked against a frame-level model.
module tb_mpc_constraint_vec_writer;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    address0 = '0;
  logic          ce0 = 1'b0;
  logic          swap_req = 1'b0;
  logic [DW-1:0] q0;
  logic          bank_sel, load_done, err_len;

  mpc_constraint_vec_writer_if #(.DataWidth(DW)) wr_if ();

  mpc_constraint_vec_writer #(.DataWidth(DW), .AddressWidth(3), .AddressRange(6)) dut (
    .clk(clk), .reset(reset), .wr(wr_if.slave),
    .address0(address0), .ce0(ce0), .q0(q0),
    .swap_req(swap_req), .bank_sel(bank_sel), .load_done(load_done), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bank contents, active bank, words received in current frame.
  logic [DW-1:0] m_bank [2][6];
  bit            m_sel;
  bit            m_pending;
  int            m_len;
  logic [DW-1:0] m_q0;
  bit            m_ready, m_load_done, m_err_len;

  task automatic model_reset();
    m_sel = 0; m_pending = 0; m_len = 0; m_q0 = '0;
    m_ready = 0; m_load_done = 0; m_err_len = 0;
  endtask

  task automatic model_step();
    m_load_done = 0;
    m_err_len   = 0;
    if (ce0) m_q0 = (address0 >= 6) ? '0 : m_bank[m_sel][address0];
    if (m_pending) begin
      if (swap_req) begin
        m_sel = !m_sel;
        m_pending = 0;
        m_load_done = 1;
      end
    end else if (wr_if.s_valid && m_ready) begin
      m_bank[!m_sel][m_len] = wr_if.s_data;
      m_len++;
      if (wr_if.s_last) begin
        if (m_len == 6) m_pending = 1;
        else m_err_len = 1;
        m_len = 0;
      end else if (m_len == 6) begin
        m_err_len = 1;
        m_len = 0;
      end
    end
    m_ready = !m_pending;
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                       input logic [2:0] a, input logic ce, input logic sw);
    wr_if.s_valid = v; wr_if.s_data = d; wr_if.s_last = l;
    address0 = a; ce0 = ce; swap_req = sw;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr_if.s_valid = 0; wr_if.s_data = '0; wr_if.s_last = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (q0 !== '0) begin errors++; $display("FAIL reset_q0 got %h exp 0", q0); end
    checks++; if (wr_if.s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wr_if.s_ready); end
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("FAIL reset_bank_sel got %b exp 0", bank_sel); end
    checks++; if (load_done !== 1'b0 || err_len !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", load_done, err_len); end
    reset = 1'b1;
  endtask

  task automatic test_default_read();
    logic [DW-1:0] exp;
    for (int a = 0; a < 6; a++) begin
      cycle(0, '0, 0, 3'(a), 1, 0);
      exp = (a % 2 == 0) ? 18'h38000 : 18'h26DE0;
      checks++; if (q0 !== exp || q0 !== m_q0) begin errors++; $display("FAIL default_read a=%0d got %h exp %h", a, q0, exp); end
    end
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("FAIL default_bank_sel got %b exp 0", bank_sel); end
  endtask

  task automatic test_commit();
    logic [DW-1:0] exp;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 18'(i + 1), i == 5, 3'(i), 0, 0);
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL commit_err beat=%0d got %b exp 0", i, err_len); end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1, 18'h3FFFF, 0, 3'(i % 6), 1, 0);
      exp = (i % 6) % 2 == 0 ? 18'h38000 : 18'h26DE0;
      checks++; if (wr_if.s_ready !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL pending_hold rdy=%b ld=%b exp 0 0", wr_if.s_ready, load_done); end
      checks++; if (q0 !== exp) begin errors++; $display("FAIL pending_read got %h exp %h", q0, exp); end
    end
    cycle(0, '0, 0, 0, 0, 1);
    checks++; if (bank_sel !== 1'b1 || load_done !== 1'b1) begin errors++; $display("FAIL swap got sel=%b ld=%b exp 1 1", bank_sel, load_done); end
    for (int a = 0; a < 6; a++) begin
      cycle(0, '0, 0, 3'(a), 1, 0);
      checks++; if (q0 !== 18'(a + 1) || load_done !== 1'b0) begin errors++; $display("FAIL new_bank_read a=%0d got %h ld=%b exp %h 0", a, q0, load_done, 18'(a + 1)); end
    end
  endtask

  task automatic test_bad_length();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 18'($urandom), i == 3, 0, 0, 1);
      checks++; if (err_len !== (i == 3) || err_len !== m_err_len) begin errors++; $display("FAIL short_err beat=%0d got %b exp %b", i, err_len, i == 3); end
    end
    checks++; if (bank_sel !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL short_no_swap sel=%b ld=%b exp 1 0", bank_sel, load_done); end
    for (int i = 0; i < 7; i++) begin
      cycle(1, 18'(16'hA0 + i), 0, 0, 0, 0);
      checks++; if (err_len !== (i == 5)) begin errors++; $display("FAIL long_err beat=%0d got %b exp %b", i, err_len, i == 5); end
    end
    // Seventh beat opened a new frame: five more words complete it.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 18'(16'hB0 + i), i == 4, 0, 0, 0);
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL cont_err beat=%0d got %b exp 0", i, err_len); end
    end
    checks++; if (wr_if.s_ready !== 1'b0) begin errors++; $display("FAIL cont_pending got %b exp 0", wr_if.s_ready); end
    cycle(0, '0, 0, 0, 0, 1);
    checks++; if (bank_sel !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL cont_swap sel=%b ld=%b exp 0 1", bank_sel, load_done); end
    for (int a = 0; a < 6; a++) begin
      cycle(0, '0, 0, 3'(a), 1, 0);
      checks++; if (q0 !== ((a == 0) ? 18'hA6 : 18'(16'hB0 + a - 1))) begin errors++; $display("FAIL cont_read a=%0d got %h", a, q0); end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      int sent = 0; int pend_wait = 0; int cyc = 0; bit swapped = 0;
      while (!swapped && cyc < 300) begin
        logic v, l, ce, sw, swap_now;
        logic [2:0] a;
        logic [DW-1:0] old_word;
        v = 1'($urandom_range(0, 1));
        l = v && (sent == 5);
        ce = 1'($urandom_range(0, 1));
        a = 3'($urandom_range(0, 7));
        sw = m_pending ? (pend_wait >= 3) : 1'($urandom_range(0, 1));
        swap_now = m_pending && sw;
        if (swap_now) begin ce = 1; a = 3'($urandom_range(0, 5)); end
        old_word = m_bank[m_sel][a < 6 ? a : 3'd0];
        if (v && m_ready && !m_pending) sent++;
        cycle(v, 18'($urandom), l, a, ce, sw);
        cyc++;
        if (m_pending) pend_wait++;
        checks++;
        if (q0 !== m_q0 || wr_if.s_ready !== m_ready || bank_sel !== m_sel ||
            load_done !== m_load_done || err_len !== m_err_len || (load_done && err_len)) begin
          errors++;
          $display("FAIL rand f=%0d cyc=%0d got q0=%h rdy=%b sel=%b ld=%b el=%b exp %h %b %b %b %b",
                   f, cyc, q0, wr_if.s_ready, bank_sel, load_done, err_len, m_q0, m_ready, m_sel, m_load_done, m_err_len);
        end
        if (swap_now) begin
          checks++; if (q0 !== old_word) begin errors++; $display("FAIL swap_edge_read got %h exp %h", q0, old_word); end
          cycle(0, '0, 0, a, 1, 0);
          checks++; if (q0 !== m_bank[m_sel][a]) begin errors++; $display("FAIL post_swap_read got %h exp %h", q0, m_bank[m_sel][a]); end
          swapped = 1;
        end
      end
      checks++; if (!swapped) begin errors++; $display("FAIL rand_timeout f=%0d got no swap exp swap", f); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1, 18'($urandom), 0, 0, 0, 0);
    reset = 1'b0; #1;
    model_reset();
    checks++; if (q0 !== '0 || wr_if.s_ready !== 1'b0 || bank_sel !== 1'b0 || load_done !== 1'b0 || err_len !== 1'b0) begin
      errors++; $display("FAIL reset_mid_load got q0=%h rdy=%b sel=%b exp 0 0 0", q0, wr_if.s_ready, bank_sel); end
    wr_if.s_valid = 0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    cycle(0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 18'(16'hC0 + i), i == 5, 0, 0, 0);
    checks++; if (wr_if.s_ready !== 1'b0) begin errors++; $display("FAIL reset_pre_pending got %b exp 0", wr_if.s_ready); end
    reset = 1'b0; #1;
    model_reset();
    checks++; if (bank_sel !== 1'b0 || load_done !== 1'b0 || q0 !== '0) begin errors++; $display("FAIL reset_pending sel=%b ld=%b q0=%h exp 0 0 0", bank_sel, load_done, q0); end
    wr_if.s_valid = 0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b1;
    cycle(0, '0, 0, 0, 0, 1);
    checks++; if (load_done !== 1'b0 || bank_sel !== 1'b0) begin errors++; $display("FAIL reset_discard ld=%b sel=%b exp 0 0", load_done, bank_sel); end
    for (int i = 0; i < 6; i++) cycle(1, 18'(16'hD0 + i), i == 5, 0, 0, 0);
    cycle(0, '0, 0, 0, 0, 1);
    checks++; if (load_done !== 1'b1 || bank_sel !== 1'b1) begin errors++; $display("FAIL reset_reload ld=%b sel=%b exp 1 1", load_done, bank_sel); end
    for (int a = 0; a < 6; a++) begin
      cycle(0, '0, 0, 3'(a), 1, 0);
      checks++; if (q0 !== 18'(16'hD0 + a) || q0 !== m_q0) begin errors++; $display("FAIL reset_reload_read a=%0d got %h exp %h", a, q0, 18'(16'hD0 + a)); end
    end
  endtask

  task automatic test_oob_hold();
    logic [DW-1:0] held;
    cycle(0, '0, 0, 3'd1, 1, 0);
    cycle(0, '0, 0, 3'd6, 1, 0);
    checks++; if (q0 !== '0) begin errors++; $display("FAIL oob6 got %h exp 0", q0); end
    cycle(0, '0, 0, 3'd2, 1, 0);
    cycle(0, '0, 0, 3'd7, 1, 0);
    checks++; if (q0 !== '0) begin errors++; $display("FAIL oob7 got %h exp 0", q0); end
    cycle(0, '0, 0, 3'd3, 1, 0);
    held = m_q0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 0, 3'($urandom_range(0, 7)), 0, 0);
      checks++; if (q0 !== held || held === '0) begin errors++; $display("FAIL hold cyc=%0d got %h exp %h", i, q0, held); end
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 6; i++)
        m_bank[b][i] = (i % 2 == 0) ? 18'h38000 : 18'h26DE0;
    model_reset();
    test_reset();
    test_default_read();
    test_commit();
    test_bad_length();
    test_random_frames();
    test_reset_mid();
    test_oob_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
